spm_page_writer: RTL

- Upstream write sequencer for the CPU-writable AVR program memory (single-port BRAM, synchronous write, registered read address).
- Collects SPM "fill buffer" words from the CPU into a one-page buffer, then performs page erase or page write by driving sequential write cycles into the PM port.
- Owns the PM address/write port: it passes the CPU fetch address through when idle and stalls the CPU while it sequences a page.

---
 rtl/spm_page_writer.sv | 88 ++++++++
 1 files changed

// File: rtl/spm_page_writer.sv
// spm_page_writer: collects SPM fill words into a page buffer and sequences page erase/write into PM
module spm_page_writer #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 13,
  parameter int PAGE_W    = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [ADDR_W-1:0]    cpu_pc_i,
  input  logic                 spm_req_i,
  input  logic [1:0]           spm_cmd_i,
  input  logic [ADDR_W-1:0]    spm_addr_i,
  input  logic [WORD_SIZE-1:0] spm_data_i,
  output logic [ADDR_W-1:0]    pm_addr_o,
  output logic                 pm_we_o,
  output logic [WORD_SIZE-1:0] pm_data_o,
  output logic                 cpu_stall_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);
  localparam int PAGE_N = 2 ** PAGE_W;
  typedef enum logic [1:0] {IDLE, ERASE, WRITE} state_e;
  state_e                     state_q, state_d;
  logic [PAGE_W-1:0]          cnt_q, cnt_d;
  logic [PAGE_N-1:0]          mask_q, mask_d;
  logic [ADDR_W-PAGE_W-1:0]   page_q, page_d;
  logic                       done_q, done_d, err_q, err_d;
  logic [WORD_SIZE-1:0]       buf_q [PAGE_N];
  logic                       idle, last, fill, start;
  logic [PAGE_W-1:0]          slot;
  assign slot  = spm_addr_i[PAGE_W-1:0];
  assign idle  = state_q == IDLE;
  assign last  = cnt_q == '1;
  assign fill  = idle && spm_req_i && spm_cmd_i == 2'b00;
  assign start = idle && spm_req_i && (spm_cmd_i == 2'b01 || spm_cmd_i == 2'b10);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    page_d  = page_q;
    done_d  = 1'b0;
    err_d   = spm_req_i && (!idle || spm_cmd_i == 2'b11);
    if (start) begin
      state_d = spm_cmd_i[0] ? ERASE : WRITE;
      page_d  = spm_addr_i[ADDR_W-1:PAGE_W];
      cnt_d   = '0;
    end
    if (fill) mask_d[slot] = 1'b1;
    if (!idle) begin
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = IDLE;
        done_d  = 1'b1;
        mask_d  = (state_q == WRITE) ? '0 : mask_q;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      page_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      page_q  <= page_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // Buffer contents are not reset; mask_q alone decides which slots are valid.
  always_ff @(posedge clk_i) begin
    if (fill) buf_q[slot] <= spm_data_i;
  end
  assign busy_o      = !idle;
  assign cpu_stall_o = !idle;
  assign pm_we_o     = !idle;
  assign pm_addr_o   = idle ? cpu_pc_i : {page_q, cnt_q};
  assign pm_data_o   = idle ? spm_data_i :
                       (state_q == WRITE && mask_q[cnt_q]) ? buf_q[cnt_q] : '1;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule
